// File: rtl/cam_alu_sched.sv
// cam_alu_sched: round-robin front end for two requesters driving an external CAM ALU.
// Each request is loaded, issued one lane per cycle, and its results collected.
// Define CAM_SCHED_STATS_EN to add the per-requester grant counters gnt_cnt0/gnt_cnt1.
module cam_alu_sched #(
    parameter int LANES   = 8,
    parameter int CAM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [2*LANES*4-1:0] req_data_l,
    input  logic [2*LANES*4-1:0] req_data_r,
    output logic                 alu_write_en,
    output logic [1:0]           alu_controller,
    output logic [LANES*4-1:0]   alu_data_l,
    output logic [LANES*4-1:0]   alu_data_r,
    output logic [3:0]           alu_pe_l,
    output logic [3:0]           alu_pe_r,
    input  logic [5:0]           alu_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [LANES*6-1:0]   rsp_data,
`ifdef CAM_SCHED_STATS_EN
    output logic [15:0]          gnt_cnt0,
    output logic [15:0]          gnt_cnt1,
`endif
    output logic [2:0]           dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // The response holds id/data stable while rsp_valid is high and rsp_ready is low.
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DW = LANES * 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t             state_q;
    logic               rr_q;
    logic [DW-1:0]      dl_q, dr_q;
    logic [LW-1:0]      lane_q;
    logic [CAM_LAT-1:0] pv_q;
    logic [LW-1:0]      pi_q [CAM_LAT];
    logic               wen_q;
    logic [1:0]         ctrl_q;
    logic [DW-1:0]      adl_q, adr_q;
    logic [3:0]         pel_q, per_q;
    logic               rsp_valid_q, rsp_id_q;
    logic [LANES*6-1:0] rsp_data_q;

    logic [1:0]         grant;
    logic [1:0]         accept;
    logic               gnt_idx;
    logic [1:0]         sel_op;
    logic [DW-1:0]      sel_dl, sel_dr;
    logic [LW-1:0]      lane_nx;
    logic [3:0]         pel_nx, per_nx;
    logic               last_lane;
    logic               cap_en;
    logic [LW-1:0]      cap_idx;

    // rr_q remembers the last granted requester; on contention the other one wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (rst_n && (state_q == IDLE)) ? grant : 2'b00;
    assign accept    = req_valid & req_ready;
    assign gnt_idx   = accept[1];
    assign sel_op    = gnt_idx ? req_op[3:2] : req_op[1:0];
    assign sel_dl    = gnt_idx ? req_data_l[2*DW-1:DW] : req_data_l[DW-1:0];
    assign sel_dr    = gnt_idx ? req_data_r[2*DW-1:DW] : req_data_r[DW-1:0];
    assign lane_nx   = lane_q + 1'b1;
    assign pel_nx    = 4'(dl_q >> {lane_nx, 2'b00});
    assign per_nx    = 4'(dr_q >> {lane_nx, 2'b00});
    assign last_lane = (lane_q == LW'(LANES - 1));
    assign cap_en    = pv_q[CAM_LAT-1];
    assign cap_idx   = pi_q[CAM_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b1;
            dl_q        <= '0;
            dr_q        <= '0;
            lane_q      <= '0;
            pv_q        <= '0;
            for (int j = 0; j < CAM_LAT; j++) pi_q[j] <= '0;
            wen_q       <= 1'b0;
            ctrl_q      <= 2'b00;
            adl_q       <= '0;
            adr_q       <= '0;
            pel_q       <= 4'h0;
            per_q       <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            // Lane-index pipeline: an issued lane reaches the last stage CAM_LAT edges later.
            for (int j = CAM_LAT - 1; j > 0; j--) begin
                pv_q[j] <= pv_q[j-1];
                pi_q[j] <= pi_q[j-1];
            end
            pv_q[0] <= 1'b0;
            pi_q[0] <= lane_q;

            for (int k = 0; k < LANES; k++) begin
                if (cap_en && (cap_idx == LW'(k))) rsp_data_q[k*6 +: 6] <= alu_res;
            end

            case (state_q)
                IDLE: begin
                    if (|accept) begin
                        state_q  <= LOAD;
                        rr_q     <= gnt_idx;
                        rsp_id_q <= gnt_idx;
                        dl_q     <= sel_dl;
                        dr_q     <= sel_dr;
                        ctrl_q   <= sel_op;
                        wen_q    <= 1'b1;
                        adl_q    <= sel_dl;
                        adr_q    <= sel_dr;
                    end
                end
                LOAD: begin
                    state_q <= ISSUE;
                    wen_q   <= 1'b0;
                    adl_q   <= '0;
                    adr_q   <= '0;
                    lane_q  <= '0;
                    pel_q   <= dl_q[3:0];
                    per_q   <= dr_q[3:0];
                end
                ISSUE: begin
                    pv_q[0] <= 1'b1;
                    if (last_lane) begin
                        state_q <= DRAIN;
                        pel_q   <= 4'h0;
                        per_q   <= 4'h0;
                    end else begin
                        lane_q <= lane_nx;
                        pel_q  <= pel_nx;
                        per_q  <= per_nx;
                    end
                end
                DRAIN: begin
                    if (cap_en && (cap_idx == LW'(LANES - 1))) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        ctrl_q      <= 2'b00;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_write_en   = wen_q;
    assign alu_controller = ctrl_q;
    assign alu_data_l     = adl_q;
    assign alu_data_r     = adr_q;
    assign alu_pe_l       = pel_q;
    assign alu_pe_r       = per_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_data       = rsp_data_q;
    assign dbg_state_o    = state_q;

`ifdef CAM_SCHED_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Saturating accept counters per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (accept[0] && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
            if (accept[1] && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif
endmodule

// File: doc/cam_alu_sched.md
CAM_ALU_SCHED -- requirements
Module: cam_alu_sched

Interface
REQ-001 The block SHALL have parameter LANES, default 8: the number of 4-bit operand lanes per request.
REQ-002 The block SHALL have parameter CAM_LAT, default 2: the number of cycles from a search issue to a valid alu_res.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, one bit per requester
- req_ready  out  2  request accepted this cycle, one-hot or zero
- req_op  in  4  2 bits per requester; 00 and, 01 or, 10 xor, 11 add
- req_data_l  in  2*LANES*4  left operands, requester i at [i*LANES*4 +: LANES*4]
- req_data_r  in  2*LANES*4  right operands, same packing
- alu_write_en  out  1  CAM load strobe
- alu_controller  out  2  ALU instruction
- alu_data_l  out  LANES*4  left CAM contents
- alu_data_r  out  LANES*4  right CAM contents
- alu_pe_l  out  4  left search key
- alu_pe_r  out  4  right search key
- alu_res  in  6  per-lane ALU result, CAM_LAT cycles after issue
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  1  requester index of the response
- rsp_data  out  LANES*6  lane k result at [k*6 +: 6]

Function
REQ-005 The block SHALL implement the FSM states IDLE, LOAD, ISSUE, DRAIN and RESP, with transitions IDLE->LOAD on accept, LOAD->ISSUE after 1 cycle, ISSUE->DRAIN after LANES cycles, DRAIN->RESP when the last lane is captured, and RESP->IDLE on rsp_valid&rsp_ready.
REQ-006 The block SHALL arbitrate in IDLE only, using round-robin:
- one valid requester is granted regardless of the pointer
- if both are valid, the requester not granted last is granted
- the pointer updates only on an accept
REQ-007 req_ready SHALL be combinational: req_ready[i] = (state==IDLE) & grant[i]; an accept is req_valid[i]&req_ready[i].
REQ-008 On accept, the block SHALL latch that requester's op, data_l and data_r, and set rsp_id to i.
REQ-009 In LOAD, the block SHALL drive alu_write_en=1 and alu_data_l/r from the latched operands; alu_write_en SHALL be 0 in all other states.
REQ-010 In ISSUE cycle k (k=0..LANES-1), the block SHALL drive alu_pe_l=data_l[k] and alu_pe_r=data_r[k].
REQ-011 alu_controller SHALL hold the latched op during LOAD, ISSUE and DRAIN, and SHALL be 0 otherwise.
REQ-012 The block SHALL sample alu_res for lane k at the clock edge that ends cycle (issue_k + CAM_LAT) and store it in rsp_data lane k; the lane index SHALL be tracked by a CAM_LAT-deep valid+index pipeline.
REQ-013 Latency SHALL be fixed: with the accept in cycle T, rsp_valid is first high in cycle T+2+LANES+CAM_LAT (T+12 at defaults).
REQ-014 rsp_valid, rsp_id and rsp_data SHALL hold stable until rsp_ready; if rsp_ready is already high when rsp_valid rises, the response completes in one cycle.
REQ-015 The block SHALL NOT accept a new request in the same cycle as a response handshake; the earliest next accept is the following cycle, in IDLE.
REQ-016 In IDLE and RESP, alu_pe_l/r and alu_data_l/r SHALL be 0.
REQ-017 alu_res SHALL be captured unmodified, including X values; the block performs no checking of it.
REQ-018 A requester that drops req_valid before being granted SHALL have no effect on the block.

Reset
REQ-019 While rst_n=0, the block SHALL be in state IDLE with:
- req_ready, alu_write_en, alu_controller, alu_data_l/r, alu_pe_l/r = 0
- rsp_valid, rsp_id, rsp_data = 0
- round-robin pointer favouring requester 0
REQ-020 A reset asserted mid-operation SHALL abort the request immediately with no response issued, and SHALL flush the capture pipeline.

Configuration
REQ-021 With CAM_SCHED_STATS_EN defined, the block SHALL add outputs gnt_cnt0 and gnt_cnt1 (16 bits each): saturating accept counters per requester, reset to 0.
REQ-022 Without CAM_SCHED_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-023 Single request: requester 0 sends op=00 with lane k data_l=k, data_r=15-k, and the ALU model returns {2'b0, l&r}; the bench SHALL see rsp_valid at T+12, rsp_id=0, and lane 3 = 6'h00.
REQ-024 Contention: both requesters are held valid from reset; the bench SHALL see grants alternate 0,1,0,1 and rsp_id follow the same order.
REQ-025 Backpressure: rsp_ready is held 0 for 5 cycles; the bench SHALL see rsp_data stable and req_ready=2'b00 throughout, then IDLE one cycle after the handshake.
REQ-026 Sequencing: the bench SHALL see alu_write_en high for exactly one cycle (T+1), and alu_pe_l take data_l[0..7] in cycles T+2..T+9.
REQ-027 Reset mid-run: rst_n is asserted during ISSUE lane 4; the bench SHALL see all outputs 0 immediately, no rsp_valid afterwards, and the next grant go to requester 0.
REQ-028 Stats (CAM_SCHED_STATS_EN): after 3 accepts from requester 1, the bench SHALL see gnt_cnt1=3 and gnt_cnt0=0.
